// File: rtl/pit_pkg.sv
// Register map, CTRL bit positions and the bus address decoder for the
// multi-channel interval timer.
package pit_pkg;

    localparam logic [7:0] PIT_PRESCALE  = 8'h00;
    localparam logic [7:0] PIT_IRQ_STAT  = 8'h04;
    localparam logic [7:0] PIT_IRQ_EN    = 8'h08;
    localparam logic [7:0] PIT_CH_BASE   = 8'h10;
    localparam logic [7:0] PIT_CH_STRIDE = 8'h10;
    localparam logic [3:0] PIT_CTRL      = 4'h0;
    localparam logic [3:0] PIT_RELOAD    = 4'h4;
    localparam logic [3:0] PIT_COUNT     = 4'h8;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRESCALE,
        REG_STAT,
        REG_EN,
        REG_CTRL,
        REG_RELOAD,
        REG_COUNT
    } pit_reg_e;

    typedef struct packed {
        pit_reg_e   sel;
        logic [3:0] ch;
    } pit_dec_t;

    // Channel index is not range-checked here; the top knows NUM_CH.
    function automatic pit_dec_t pit_decode(input logic [5:0] word);
        pit_dec_t   d;
        logic [7:0] a;
        logic [7:0] off;
        d.sel = REG_NONE;
        d.ch  = '0;
        a     = {word, 2'b00};
        off   = a - PIT_CH_BASE;
        if (a == PIT_PRESCALE) begin
            d.sel = REG_PRESCALE;
        end else if (a == PIT_IRQ_STAT) begin
            d.sel = REG_STAT;
        end else if (a == PIT_IRQ_EN) begin
            d.sel = REG_EN;
        end else if (a >= PIT_CH_BASE) begin
            d.ch = 4'(off / PIT_CH_STRIDE);
            case (4'(off % PIT_CH_STRIDE))
                PIT_CTRL:   d.sel = REG_CTRL;
                PIT_RELOAD: d.sel = REG_RELOAD;
                PIT_COUNT:  d.sel = REG_COUNT;
                default:    d.sel = REG_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/pit_multi_if.sv
// Wishbone slave bus of the interval timer, as seen from the master and the slave.
interface pit_multi_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                    input  dat_o, ack_o);
    modport slave  (input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                    output dat_o, ack_o);
endinterface

// File: rtl/pit_channel.sv
// One timer channel: CTRL, RELOAD and the down-counter, advanced by the shared tick.
module pit_channel
    import pit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick_i,
    input  logic             ctrl_we_i,
    input  logic             reload_we_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] reload_o,
    output logic [1:0]       ctrl_o,
    output logic             expire_o
);

    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] count_q;
    logic             unused_wdata;

    assign unused_wdata = ^wdata_i;

    // A CTRL write in the same cycle as a tick suppresses that tick.
    assign expire_o = tick_i && ctrl_q[CTRL_EN] && (count_q == '0) && !ctrl_we_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
        end else begin
            if (ctrl_we_i) begin
                ctrl_q <= wdata_i[1:0];
                if (wdata_i[CTRL_EN]) count_q <= reload_q;
            end else if (tick_i && ctrl_q[CTRL_EN]) begin
                if (count_q != '0)               count_q <= count_q - CNT_W'(1);
                else if (ctrl_q[CTRL_PERIODIC])  count_q <= reload_q;
                else                             ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (reload_we_i) reload_q <= wdata_i[CNT_W-1:0];
        end
    end

    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign ctrl_o   = ctrl_q;

endmodule

// File: rtl/pit_multi.sv
// Multi-channel programmable interval timer: Wishbone register file, shared
// prescaler, sticky interrupt status with per-channel enable.
module pit_multi
    import pit_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PRE_W  = 16
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    pit_multi_if.slave wb,
    output logic      int_o
);

    logic              accept;
    logic              wr_en;
    pit_dec_t          dec;
    logic              tick;
    logic [PRE_W-1:0]  prescale_q;
    logic [PRE_W-1:0]  pre_cnt_q;
    logic [NUM_CH-1:0] stat_q, stat_d;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] w1c;
    logic              ack_q;
    logic              int_q;
    logic [31:0]       dat_q;
    logic [31:0]       rd_data;
    logic [CNT_W-1:0]  ch_count  [NUM_CH];
    logic [CNT_W-1:0]  ch_reload [NUM_CH];
    logic [1:0]        ch_ctrl   [NUM_CH];
    logic              unused_bus;

    assign unused_bus = ^{wb.adr_i[31:8], wb.adr_i[1:0], wb.dat_i};

    assign accept = wb.cyc_i && wb.stb_i && !ack_q;
    assign wr_en  = accept && wb.we_i && (wb.sel_i == 4'hF);
    assign dec    = pit_decode(wb.adr_i[7:2]);
    assign tick   = (pre_cnt_q == prescale_q);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pit_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .tick_i      (tick),
            .ctrl_we_i   (wr_en && dec.sel == REG_CTRL   && dec.ch == 4'(n)),
            .reload_we_i (wr_en && dec.sel == REG_RELOAD && dec.ch == 4'(n)),
            .wdata_i     (wb.dat_i),
            .count_o     (ch_count[n]),
            .reload_o    (ch_reload[n]),
            .ctrl_o      (ch_ctrl[n]),
            .expire_o    (expire[n])
        );
    end

    // Hardware set takes priority over a simultaneous write-1-to-clear.
    always_comb begin
        w1c    = (wr_en && dec.sel == REG_STAT) ? wb.dat_i[NUM_CH-1:0] : '0;
        stat_d = (stat_q & ~w1c) | expire;
    end

    always_comb begin
        rd_data = '0;
        case (dec.sel)
            REG_PRESCALE: rd_data[PRE_W-1:0]  = prescale_q;
            REG_STAT:     rd_data[NUM_CH-1:0] = stat_q;
            REG_EN:       rd_data[NUM_CH-1:0] = en_q;
            default: begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (dec.ch == 4'(n)) begin
                        case (dec.sel)
                            REG_CTRL:   rd_data[1:0]       = ch_ctrl[n];
                            REG_RELOAD: rd_data[CNT_W-1:0] = ch_reload[n];
                            REG_COUNT:  rd_data[CNT_W-1:0] = ch_count[n];
                            default:    ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            stat_q     <= '0;
            en_q       <= '0;
            ack_q      <= 1'b0;
            int_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            ack_q  <= accept;
            int_q  <= |(stat_q & en_q);
            stat_q <= stat_d;
            if (accept && !wb.we_i) dat_q <= rd_data;
            if (wr_en && dec.sel == REG_EN) en_q <= wb.dat_i[NUM_CH-1:0];
            if (wr_en && dec.sel == REG_PRESCALE) begin
                prescale_q <= wb.dat_i[PRE_W-1:0];
                pre_cnt_q  <= '0;
            end else begin
                pre_cnt_q  <= tick ? '0 : pre_cnt_q + PRE_W'(1);
            end
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;
    assign int_o    = int_q;

endmodule

// File: tb/tb_pit_multi.sv
// Randomised and directed bench for pit_multi with a rule-level reference model and scoreboard.
module tb_pit_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PRE_W  = 16;
    localparam longint unsigned CMASK = (64'd1 << CNT_W) - 1;
    localparam longint unsigned PMASK = (64'd1 << PRE_W) - 1;
    localparam bit [7:0] NMASK = 8'((1 << NUM_CH) - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic int_o;

    pit_multi_if bus ();

    pit_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .wb      (bus),
        .int_o   (int_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit is_rd; bit [31:0] data; } exp_t;
    exp_t sb[$];

    longint unsigned m_pre_val, m_pre_cnt;
    longint unsigned m_reload [NUM_CH];
    longint unsigned m_count  [NUM_CH];
    bit [1:0]        m_ctrl   [NUM_CH];
    bit [7:0]        m_stat, m_en;
    bit              m_ack, m_int;

    bit           md_acc, md_wr, md_tick;
    bit [7:0]     md_set, md_w1c;
    int unsigned  md_off;
    exp_t         md_e;

    function automatic bit [31:0] model_read(input bit [31:0] a);
        int unsigned off, ch, r;
        off = a[7:0] & 8'hFC;
        if (off == 0) return 32'(m_pre_val);
        if (off == 4) return {24'b0, m_stat};
        if (off == 8) return {24'b0, m_en};
        if (off >= 16) begin
            ch = (off - 16) / 16;
            r  = (off - 16) % 16;
            if (ch < NUM_CH) begin
                if (r == 0) return {30'b0, m_ctrl[ch]};
                if (r == 4) return 32'(m_reload[ch]);
                if (r == 8) return 32'(m_count[ch]);
            end
        end
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre_val = 0; m_pre_cnt = 0; m_stat = 0; m_en = 0; m_ack = 0; m_int = 0;
            for (int n = 0; n < NUM_CH; n++) begin
                m_reload[n] = 0; m_count[n] = 0; m_ctrl[n] = 0;
            end
            sb.delete();
        end else begin
            md_acc = bus.cyc_i && bus.stb_i && !m_ack;
            md_wr  = md_acc && bus.we_i && bus.sel_i == 4'hF;
            md_off = bus.adr_i[7:0] & 8'hFC;
            if (md_acc) begin
                md_e.is_rd = !bus.we_i;
                md_e.data  = model_read(bus.adr_i);
                sb.push_back(md_e);
            end
            md_tick = (m_pre_cnt == m_pre_val);
            m_int   = |(m_stat & m_en);
            md_set  = 0;
            md_w1c  = 0;
            for (int n = 0; n < NUM_CH; n++) begin
                if (md_wr && md_off == 16 + 16 * n) begin
                    m_ctrl[n] = bus.dat_i[1:0];
                    if (bus.dat_i[0]) m_count[n] = m_reload[n];
                end else if (md_tick && m_ctrl[n][0]) begin
                    if (m_count[n] != 0) m_count[n] = m_count[n] - 1;
                    else begin
                        md_set[n] = 1'b1;
                        if (m_ctrl[n][1]) m_count[n] = m_reload[n];
                        else              m_ctrl[n][0] = 1'b0;
                    end
                end
                if (md_wr && md_off == 16 + 16 * n + 4) m_reload[n] = bus.dat_i & CMASK;
            end
            if (md_wr && md_off == 4) md_w1c = bus.dat_i[7:0] & NMASK;
            m_stat = ((m_stat & ~md_w1c) | md_set) & NMASK;
            if (md_wr && md_off == 8) m_en = bus.dat_i[7:0] & NMASK;
            if (md_wr && md_off == 0) begin
                m_pre_val = bus.dat_i & PMASK;
                m_pre_cnt = 0;
            end else begin
                m_pre_cnt = md_tick ? 0 : m_pre_cnt + 1;
            end
            m_ack = md_acc;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ack_o", bus.ack_o, m_ack);
            check("int_o", int_o, m_int);
            if (bus.ack_o) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_rd) check("rdata", bus.dat_o, mon_e.data);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit we, input bit [31:0] adr, input bit [31:0] dat,
                        input bit [3:0] sel, output bit [31:0] rd);
        bit got;
        got = 0;
        rd  = '0;
        @(negedge clk);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = we;
        bus.adr_i = adr; bus.dat_i = dat; bus.sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ack_o) begin
                got = 1;
                rd  = bus.dat_o;
            end
        end
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
        check("ack_timeout", got, 1);
    endtask

    task automatic wr(input bit [31:0] adr, input bit [31:0] dat);
        bit [31:0] d;
        xfer(1, adr, dat, 4'hF, d);
    endtask

    task automatic rd_expect(input string name, input bit [31:0] adr, input bit [31:0] exp);
        bit [31:0] d;
        xfer(0, adr, 0, 4'hF, d);
        check(name, d, exp);
    endtask

    task automatic wait_int_rise(output int unsigned t);
        bit prev, ok;
        prev = int_o;
        ok   = 0;
        t    = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (int_o && !prev) begin
                ok = 1;
                t  = cyc_cnt;
            end
            prev = int_o;
        end
        check("int_rise_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0]   d;
        int unsigned t1, t2, tw, acks, pick;
        bit          prev, b2b;
        bit [31:0]   adr, dat;
        bit [3:0]    sel;

        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
        bus.sel_i = 0; bus.adr_i = 0; bus.dat_i = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Mid-run reset with an access in flight
        wr(32'h00, 2);
        wr(32'h08, 32'hF);
        wr(32'h14, 3);
        wr(32'h10, 3);
        repeat (20) @(negedge clk);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'h14; bus.sel_i = 4'hF;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_ack", bus.ack_o, 0);
        check("rst_int", int_o, 0);
        check("rst_dat", bus.dat_o, 0);
        @(negedge clk);
        bus.cyc_i = 0; bus.stb_i = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        rd_expect("rst_prescale", 32'h00, 0);
        rd_expect("rst_stat", 32'h04, 0);
        rd_expect("rst_en", 32'h08, 0);
        for (int n = 0; n < NUM_CH; n++) begin
            rd_expect("rst_ctrl",   32'h10 + 16 * n, 0);
            rd_expect("rst_reload", 32'h14 + 16 * n, 0);
            rd_expect("rst_count",  32'h18 + 16 * n, 0);
        end

        // Periodic: (9+1)*(3+1) = 40 clocks between expiries
        wr(32'h00, 3);
        wr(32'h14, 9);
        wr(32'h08, 1);
        wr(32'h10, 3);
        wait_int_rise(t1);
        wr(32'h04, 1);
        @(negedge clk);
        check("w1c_int_low", int_o, 0);
        wait_int_rise(t2);
        check("period", t2 - t1, 40);

        // One-shot on ch1
        wr(32'h10, 0);
        wr(32'h00, 0);
        wr(32'h04, 32'hF);
        wr(32'h08, 2);
        wr(32'h24, 5);
        wr(32'h20, 1);
        tw = cyc_cnt;
        wait_int_rise(t1);
        check("oneshot_latency", t1 - tw, 7);
        repeat (10) @(negedge clk);
        rd_expect("oneshot_count", 32'h28, 0);
        rd_expect("oneshot_ctrl", 32'h20, 0);
        rd_expect("oneshot_stat", 32'h04, 32'h2);

        // Collision: RELOAD=0 periodic with PRESCALE=0 expires every clock
        wr(32'h14, 0);
        wr(32'h10, 3);
        wr(32'h04, 1);
        xfer(0, 32'h04, 0, 4'hF, d);
        check("collision_stat0", d & 1, 1);
        wr(32'h10, 0);
        wr(32'h04, 32'hF);
        rd_expect("stat_cleared", 32'h04, 0);

        // Bus edge cases
        xfer(1, 32'h24, 32'hABCD, 4'b0011, d);
        rd_expect("partial_write", 32'h24, 5);
        rd_expect("ch_oob", 32'h10 + 16 * NUM_CH, 0);
        rd_expect("unmapped_0c", 32'h0C, 0);
        rd_expect("unmapped_1c", 32'h1C, 0);
        wr(32'h34, 32'hFFFF_FFFF);
        rd_expect("reload_max", 32'h34, 32'hFFFF_FFFF);

        @(negedge clk);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'h24; bus.sel_i = 4'hF;
        acks = 0; prev = 0; b2b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack_o) acks++;
            if (bus.ack_o && prev) b2b = 1;
            prev = bus.ack_o;
        end
        bus.cyc_i = 0; bus.stb_i = 0;
        check("held_acks", acks, 4);
        check("ack_back_to_back", b2b, 0);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      adr = 32'h00;
            else if (pick == 1) adr = 32'h04;
            else if (pick == 2) adr = 32'h08;
            else if (pick == 9) adr = $urandom & 32'hFF;
            else adr = 32'h10 + 16 * $urandom_range(0, NUM_CH) + 4 * $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) adr = adr | ($urandom & 32'hFFFF_FF03);
            sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            dat = ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 12);
            xfer(1'($urandom_range(0, 1)), adr, dat, sel, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
